// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan controller: scan FSM states,
// digit count and the all-dark common/segment patterns.
package fnd_pkg;

    localparam int unsigned FND_DIGITS = 4;
    localparam logic [3:0]  COM_OFF    = 4'b1111;
    localparam logic [7:0]  SEG_OFF    = 8'hFF;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

    // Active-low one-cold common select for digit idx.
    function automatic logic [3:0] com_select(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/fnd_scan_ctrl_decoder.sv
// Hex nibble to 7-segment glyph, active-low, segment order {a,b,c,d,e,f,g}.
module decoder_7seg (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        case (hex_i)
            4'h0: seg_o = 7'b000_0001;
            4'h1: seg_o = 7'b100_1111;
            4'h2: seg_o = 7'b001_0010;
            4'h3: seg_o = 7'b000_0110;
            4'h4: seg_o = 7'b100_1100;
            4'h5: seg_o = 7'b010_0100;
            4'h6: seg_o = 7'b010_0000;
            4'h7: seg_o = 7'b000_1111;
            4'h8: seg_o = 7'b000_0000;
            4'h9: seg_o = 7'b000_0100;
            4'hA: seg_o = 7'b000_1000;
            4'hB: seg_o = 7'b110_0000;
            4'hC: seg_o = 7'b011_0001;
            4'hD: seg_o = 7'b100_0010;
            4'hE: seg_o = 7'b011_0000;
            4'hF: seg_o = 7'b011_1000;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed 4-digit common-anode FND scanner with guard blanking,
// per-frame input snapshot, leading-zero blanking and decimal points.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter int unsigned BLANK_CYC   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp_en,
    input  logic        blank_lz,
    output logic [3:0]  com,
    output logic [7:0]  seg_7,
    output logic        frame_start
);

    localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned IDX_W   = $clog2(FND_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(FND_DIGITS - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             init_q, init_d;
    logic             snap_load;

    logic [15:0]      value_snap_q;
    logic [3:0]       dp_snap_q;
    logic             blz_snap_q;

    logic [3:0]       com_q, com_d;
    logic [7:0]       seg_q, seg_d;
    logic             fs_q, fs_d;

    logic [3:0]       nibble;
    logic [6:0]       dec_seg;
    logic [3:0]       lz_blank;

    // init_q marks the reset-released BLANK so the first frame still
    // gets its own snapshot and frame_start on the first clock.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        init_d    = 1'b0;
        snap_load = 1'b0;
        if (!enable) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else if (init_q) begin
            state_d   = ST_BLANK;
            idx_d     = '0;
            cnt_d     = '0;
            snap_load = 1'b1;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d   = ST_BLANK;
                    idx_d     = '0;
                    cnt_d     = '0;
                    snap_load = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        state_d   = ST_BLANK;
                        cnt_d     = '0;
                        idx_d     = idx_q + IDX_W'(1);
                        snap_load = (idx_q == IDX_LAST);
                    end
                end
                default: begin
                    state_d   = ST_BLANK;
                    idx_d     = '0;
                    cnt_d     = '0;
                    snap_load = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            init_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            init_q  <= init_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_snap_q <= '0;
            dp_snap_q    <= '0;
            blz_snap_q   <= 1'b0;
        end else if (snap_load) begin
            value_snap_q <= value;
            dp_snap_q    <= dp_en;
            blz_snap_q   <= blank_lz;
        end
    end

    // Digit k is blank only when it and every digit above it are zero.
    always_comb begin
        lz_blank    = '0;
        lz_blank[3] = blz_snap_q & (value_snap_q[15:12] == 4'h0);
        lz_blank[2] = lz_blank[3] & (value_snap_q[11:8] == 4'h0);
        lz_blank[1] = lz_blank[2] & (value_snap_q[7:4]  == 4'h0);
    end

    assign nibble = value_snap_q[{idx_q, 2'b00} +: 4];

    decoder_7seg u_dec (
        .hex_i (nibble),
        .seg_o (dec_seg)
    );

    always_comb begin
        com_d = COM_OFF;
        seg_d = SEG_OFF;
        fs_d  = snap_load;
        if (state_d == ST_DRIVE) begin
            com_d = com_select(idx_q);
            seg_d = {(lz_blank[idx_q] ? SEG_BLANK : dec_seg), ~dp_snap_q[idx_q]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            com_q <= COM_OFF;
            seg_q <= SEG_OFF;
            fs_q  <= 1'b0;
        end else begin
            com_q <= com_d;
            seg_q <= seg_d;
            fs_q  <= fs_d;
        end
    end

    assign com         = com_q;
    assign seg_7       = seg_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: stimulus pushes per-frame digit
// expectations, a negedge monitor pops them as each digit is driven.
module tb_fnd_scan_ctrl;

    localparam int unsigned RDIV  = 8;
    localparam int unsigned BCYC  = 2;
    localparam int unsigned FRAME = 4 * (RDIV + BCYC);
    localparam int unsigned NRAND = 20;

    typedef struct {
        logic [3:0] com;
        logic [7:0] seg;
    } exp_t;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  dp;
        logic        blz;
        int          gat;
        logic [15:0] gv;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] value;
    logic [3:0]  dp_en;
    logic        blank_lz;
    logic [3:0]  com;
    logic [7:0]  seg_7;
    logic        frame_start;

    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b1;
    exp_t sb_q[$];

    // Glyphs as full active-low bytes with the DP segment off.
    logic [7:0] glyph [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    fnd_scan_ctrl #(
        .REFRESH_DIV (RDIV),
        .BLANK_CYC   (BCYC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .value       (value),
        .dp_en       (dp_en),
        .blank_lz    (blank_lz),
        .com         (com),
        .seg_7       (seg_7),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [15:0] v, input logic [3:0] dp, input logic blz);
        exp_t e;
        int   nib;
        bit   blank;
        for (int k = 0; k < 4; k++) begin
            nib   = (int'(v) >> (4 * k)) & 15;
            blank = blz && (k > 0) && ((int'(v) >> (4 * k)) == 0);
            e.seg = blank ? 8'hFF : glyph[nib];
            e.seg[0] = ~dp[k];
            e.com = 4'hF & ~(4'd1 << k);
            sb_q.push_back(e);
        end
    endtask

    // Monitor: compares each driven digit against the scoreboard and
    // checks blank/drive lengths and frame_start spacing.
    initial begin
        bit         armed = 1'b0;
        bit         have_fs, had_drive, stable;
        int         cyc, last_fs, dark_run, drive_run;
        logic [3:0] pcom, cur_com;
        logic [7:0] cur_seg;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                armed = 1'b0;
                continue;
            end
            if (!armed) begin
                armed = 1'b1; have_fs = 1'b0; had_drive = 1'b0; stable = 1'b1;
                cyc = 0; last_fs = 0; dark_run = 0; drive_run = 0; pcom = 4'hF;
                cur_com = 4'hF; cur_seg = 8'hFF;
            end
            cyc++;
            if (frame_start) begin
                check("fs_dark", com, 4'hF);
                if (have_fs) check("fs_period", cyc - last_fs, FRAME);
                have_fs = 1'b1;
                last_fs = cyc;
            end
            if (com != 4'hF) begin
                if (pcom == 4'hF) begin
                    if (had_drive) check("blank_len", dark_run, BCYC);
                    if (com == 4'hE) check("fs_to_digit0", have_fs ? cyc - last_fs : 999, BCYC);
                    if (sb_q.size() == 0) begin
                        check("sb_empty", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("com", com, e.com);
                        check("seg", seg_7, e.seg);
                    end
                    cur_com = com; cur_seg = seg_7; drive_run = 1; stable = 1'b1;
                end else begin
                    drive_run++;
                    if (com != cur_com || seg_7 != cur_seg) stable = 1'b0;
                end
            end else begin
                check("dark_seg", seg_7, 8'hFF);
                if (pcom != 4'hF) begin
                    check("drive_len", drive_run, RDIV);
                    check("drive_stable", stable, 1);
                    had_drive = 1'b1;
                    dark_run = 1;
                end else begin
                    dark_run++;
                end
            end
            pcom = com;
        end
    end

    initial begin
        frame_t dir [6];
        frame_t fr;
        dir[0] = '{16'h1234, 4'b0000, 1'b0, 15, 16'hABCD};
        dir[1] = '{16'hABCD, 4'b0000, 1'b0, 0,  16'h0000};
        dir[2] = '{16'h0050, 4'b0000, 1'b1, 0,  16'h0000};
        dir[3] = '{16'h0000, 4'b0000, 1'b1, 0,  16'h0000};
        dir[4] = '{16'h0500, 4'b1000, 1'b1, 0,  16'h0000};
        dir[5] = '{16'h8888, 4'b0100, 1'b0, 0,  16'h0000};

        reset_n = 1'b0; enable = 1'b1; value = 16'h1234; dp_en = 4'b0000; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_com", com, 4'hF);
        check("rst_seg", seg_7, 8'hFF);
        check("rst_fs", frame_start, 0);

        for (int f = 0; f < 6 + NRAND; f++) begin
            if (f < 6) begin
                fr = dir[f];
                if (f > 0) begin
                    fr.gat = int'($urandom_range(1, FRAME - 1));
                    fr.gv  = 16'($urandom);
                end
            end else begin
                fr.v   = 16'($urandom >> $urandom_range(0, 28));
                fr.dp  = 4'($urandom);
                fr.blz = 1'($urandom);
                fr.gat = int'($urandom_range(1, FRAME - 1));
                fr.gv  = 16'($urandom);
            end
            value = fr.v; dp_en = fr.dp; blank_lz = fr.blz;
            if (f == 0) reset_n = 1'b1;
            push_frame(fr.v, fr.dp, fr.blz);
            for (int c = 1; c < int'(FRAME); c++) begin
                @(negedge clk);
                if (c == fr.gat) begin
                    value = fr.gv; dp_en = 4'($urandom); blank_lz = 1'($urandom);
                end
            end
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        check("sb_drained", sb_q.size(), 0);
        sb_q.delete();

        repeat (3) @(negedge clk);
        check("pre_disable_digit0", com, 4'hE);
        enable = 1'b0;
        @(negedge clk);
        check("disable_com", com, 4'hF);
        check("disable_seg", seg_7, 8'hFF);
        value = 16'h1234; dp_en = 4'b0000; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        check("off_com", com, 4'hF);
        check("off_fs", frame_start, 0);
        enable = 1'b1;
        @(negedge clk);
        check("reen_fs", frame_start, 1);
        check("reen_dark", com, 4'hF);
        @(negedge clk);
        check("reen_fs_pulse", frame_start, 0);
        check("reen_blank2", com, 4'hF);
        @(negedge clk);
        check("reen_com", com, 4'hE);
        check("reen_seg", seg_7, 8'h99);

        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_rst_com", com, 4'hF);
        check("async_rst_seg", seg_7, 8'hFF);
        check("async_rst_fs", frame_start, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_fs", frame_start, 1);
        @(negedge clk);
        check("rel_dark", com, 4'hF);
        @(negedge clk);
        check("rel_com", com, 4'hE);
        check("rel_seg", seg_7, 8'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
